load_store_queue: RTL and testbench

- In-order load/store buffer for the Tomasulo core. Sits beside the ALU and MUL reservation stations.
- Issue side: accepts lw/sw from the decoder/CU and snoops the CDB for pending base and store-data operands.
- Memory side: drives a synchronous data memory, then requests the CDB to broadcast each load result under the entry's tag.
- Occupies CDB requester slot 3.

---
 rtl/load_store_queue_pkg.sv | 30 +++
 rtl/load_store_queue_lsq_entry.sv | 55 +++++
 rtl/load_store_queue.sv | 127 ++++++++++++
 tb/tb_load_store_queue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_queue_pkg.sv
// Shared encodings for the load/store queue: opcodes, tags, FSM states and the
// per-slot payload record.
package load_store_queue_pkg;

  localparam logic [1:0] LS_OP_LW    = 2'd0;
  localparam logic [1:0] LS_OP_SW    = 2'd1;
  localparam logic [3:0] NO_LABEL    = 4'd0;
  localparam int         LSQ_CDB_IDX = 3;

  typedef enum logic [1:0] {
    LSQ_IDLE   = 2'd0,
    LSQ_LD_RD  = 2'd1,
    LSQ_LD_CDB = 2'd2,
    LSQ_ST_WR  = 2'd3
  } lsq_state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] v1;
    logic [3:0]  q1;
    logic [31:0] v2;
    logic [3:0]  q2;
    logic [15:0] immd;
  } lsq_slot_t;

  function automatic logic [31:0] lsq_eff_addr(input logic [31:0] base, input logic [15:0] immd);
    return base + {{16{immd[15]}}, immd};
  endfunction

endpackage

// File: rtl/load_store_queue_lsq_entry.sv
// One queue slot: holds an issued lw/sw and snoops the CDB for its pending
// base/data operands, including a same-cycle bypass at issue.
module lsq_entry
  import load_store_queue_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic        wr_en_i,
  input  logic        retire_i,
  input  lsq_slot_t   slot_i,
  input  logic        bc_en_i,
  input  logic [3:0]  bc_label_i,
  input  logic [31:0] bc_data_i,
  output logic        valid_o,
  output lsq_slot_t   slot_o
);

  logic      valid_q, valid_d;
  lsq_slot_t slot_q, slot_d;

  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    if (wr_en_i) begin
      valid_d = 1'b1;
      slot_d  = slot_i;
    end
    // Same capture rule serves the issue bypass and the resident snoop.
    if (wr_en_i || valid_q) begin
      if (bc_en_i && slot_d.q1 != NO_LABEL && slot_d.q1 == bc_label_i) begin
        slot_d.v1 = bc_data_i;
        slot_d.q1 = NO_LABEL;
      end
      if (bc_en_i && slot_d.q2 != NO_LABEL && slot_d.q2 == bc_label_i) begin
        slot_d.v2 = bc_data_i;
        slot_d.q2 = NO_LABEL;
      end
    end
    if (retire_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  assign valid_o = valid_q;
  assign slot_o  = slot_q;

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: issues lw/sw into a circular buffer of lsq_entry
// slots, executes the head against a synchronous memory, broadcasts loads on the CDB.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter logic [3:0] LABEL_BASE = 4'd12,
  parameter int         ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              WEN,
  input  logic [1:0]        opCode,
  input  logic [31:0]       dataIn1,
  input  logic [3:0]        label1,
  input  logic [31:0]       dataIn2,
  input  logic [3:0]        label2,
  input  logic [15:0]       immd16,
  output logic              isFull,
  output logic [3:0]        writeable_labelOut,
  input  logic              BCEN,
  input  logic [3:0]        BClabel,
  input  logic [31:0]       BCdata,
  output logic              require,
  input  logic              requireAC,
  output logic [31:0]       dataOut,
  output logic [3:0]        labelOut,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lsq_state_e       state_q, state_d;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      dout_q;
  logic [3:0]       lout_q;

  logic             issue, retire, head_ready, head_is_sw;
  logic             valids [DEPTH];
  lsq_slot_t        slots  [DEPTH];
  lsq_slot_t        head_slot, new_slot;

  assign isFull             = (count_q == CNT_W'(DEPTH));
  assign issue              = WEN && !isFull;
  assign writeable_labelOut = LABEL_BASE + 4'(tail_q);

  assign new_slot = '{op: opCode, v1: dataIn1, q1: label1, v2: dataIn2, q2: label2, immd: immd16};

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    lsq_entry u_entry (
      .clk        (clk),
      .nRST       (nRST),
      .wr_en_i    (issue && (tail_q == PTR_W'(i))),
      .retire_i   (retire && (head_q == PTR_W'(i))),
      .slot_i     (new_slot),
      .bc_en_i    (BCEN),
      .bc_label_i (BClabel),
      .bc_data_i  (BCdata),
      .valid_o    (valids[i]),
      .slot_o     (slots[i])
    );
  end

  assign head_slot  = slots[head_q];
  assign head_is_sw = (head_slot.op == LS_OP_SW);
  assign head_ready = valids[head_q] && (head_slot.q1 == NO_LABEL) &&
                      (!head_is_sw || head_slot.q2 == NO_LABEL);

  always_ff @(posedge clk) begin
    if (!nRST) state_q <= LSQ_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSQ_IDLE:   if (head_ready) state_d = head_is_sw ? LSQ_ST_WR : LSQ_LD_RD;
      LSQ_LD_RD:  state_d = LSQ_LD_CDB;
      LSQ_LD_CDB: if (requireAC) state_d = LSQ_IDLE;
      LSQ_ST_WR:  state_d = LSQ_IDLE;
      default:    state_d = LSQ_IDLE;
    endcase
  end

  always_comb begin
    require   = (state_q == LSQ_LD_CDB);
    mem_rd    = (state_q == LSQ_IDLE) && head_ready && !head_is_sw;
    mem_we    = (state_q == LSQ_ST_WR);
    retire    = mem_we || (require && requireAC);
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_rd || mem_we) mem_addr = ADDR_W'(lsq_eff_addr(head_slot.v1, head_slot.immd) >> 2);
    if (mem_we) mem_wdata = head_slot.v2;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      lout_q  <= '0;
    end else begin
      if (issue)  tail_q <= tail_q + 1'b1;
      if (retire) head_q <= head_q + 1'b1;
      case ({issue, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (state_q == LSQ_LD_RD) begin
        dout_q <= mem_rdata;
        lout_q <= LABEL_BASE + 4'(head_q);
      end
    end
  end

  assign dataOut  = dout_q;
  assign labelOut = lout_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: table of single lw/sw operations plus
// hand-written sequences for snoop, full queue, CDB backpressure and reset.
module tb_load_store_queue;
  import load_store_queue_pkg::*;

  logic        clk = 1'b0;
  logic        nRST, WEN, BCEN, requireAC;
  logic [1:0]  opCode;
  logic [31:0] dataIn1, dataIn2, BCdata, mem_rdata;
  logic [3:0]  label1, label2, BClabel;
  logic [15:0] immd16;
  logic        isFull, require, mem_rd, mem_we;
  logic [3:0]  writeable_labelOut, labelOut;
  logic [31:0] dataOut, mem_wdata;
  logic [7:0]  mem_addr;

  int checks = 0;
  int errors = 0;
  int tail_m = 0;

  always #5 clk = ~clk;

  load_store_queue #(.DEPTH(4), .LABEL_BASE(4'd12), .ADDR_W(8)) dut (
    .clk(clk), .nRST(nRST), .WEN(WEN), .opCode(opCode),
    .dataIn1(dataIn1), .label1(label1), .dataIn2(dataIn2), .label2(label2),
    .immd16(immd16), .isFull(isFull), .writeable_labelOut(writeable_labelOut),
    .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
    .require(require), .requireAC(requireAC), .dataOut(dataOut), .labelOut(labelOut),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: unwritten words read as C0DE0000 + address.
  logic [31:0]  mem [256];
  logic [255:0] mem_vld = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      mem_vld[mem_addr] <= 1'b1;
    end
    if (mem_rd) mem_rdata <= mem_vld[mem_addr] ? mem[mem_addr] : (32'hC0DE_0000 + 32'(mem_addr));
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] base;
    logic [15:0] immd;
    logic [31:0] data;
    logic [7:0]  exp_addr;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] d1, input logic [3:0] l1,
                       input logic [31:0] d2, input logic [3:0] l2, input logic [15:0] imm);
    @(negedge clk);
    opCode = op; dataIn1 = d1; label1 = l1; dataIn2 = d2; label2 = l2; immd16 = imm;
    WEN = 1'b1;
    @(posedge clk);
    #1 WEN = 1'b0;
  endtask

  // sel: 0 = mem_we, 1 = mem_rd, 2 = require; returns at the negedge where it is seen.
  task automatic wait_for(input int sel, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((sel == 0 && mem_we) || (sel == 1 && mem_rd) || (sel == 2 && require)) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic grant_pulse(input string name);
    requireAC = 1'b1;
    @(posedge clk);
    #1 requireAC = 1'b0;
    @(negedge clk);
    check({name, "_req_drop"}, 32'(require), 32'd0);
  endtask

  task automatic bcast(input logic [3:0] tag, input logic [31:0] val);
    @(negedge clk);
    BCEN = 1'b1; BClabel = tag; BCdata = val;
    @(posedge clk);
    #1 BCEN = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 nRST = 1'b1;
    tail_m = 0;
  endtask

  initial begin
    logic [3:0] exp_lbl;
    int         seen;

    nRST = 1'b0; WEN = 1'b0; BCEN = 1'b0; requireAC = 1'b0;
    opCode = LS_OP_LW; dataIn1 = '0; dataIn2 = '0; label1 = '0; label2 = '0;
    immd16 = '0; BClabel = '0; BCdata = '0;

    vecs[0] = '{LS_OP_SW, 32'h0000_0010, 16'h0004, 32'hDEAD_BEEF, 8'h05, 32'hDEAD_BEEF};
    vecs[1] = '{LS_OP_LW, 32'h0000_0010, 16'h0004, 32'h0,         8'h05, 32'hDEAD_BEEF};
    vecs[2] = '{LS_OP_SW, 32'h0000_0100, 16'hFFFC, 32'h1234_5678, 8'h3F, 32'h1234_5678};
    vecs[3] = '{LS_OP_LW, 32'h0000_0000, 16'h00FC, 32'h0,         8'h3F, 32'h1234_5678};
    vecs[4] = '{LS_OP_SW, 32'h0000_0403, 16'h0001, 32'hA5A5_0001, 8'h01, 32'hA5A5_0001};
    vecs[5] = '{LS_OP_LW, 32'h0000_0007, 16'hFFFF, 32'h0,         8'h01, 32'hA5A5_0001};
    vecs[6] = '{LS_OP_LW, 32'h0000_0000, 16'h0050, 32'h0,         8'h14, 32'hC0DE_0014};

    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_require", 32'(require), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_isFull", 32'(isFull), 32'd0);
    check("rst_dataOut", dataOut, 32'd0);
    check("rst_labelOut", 32'(labelOut), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_wlabel", 32'(writeable_labelOut), 32'd12);

    // Back-to-back sw then lw to the same word, grant held high
    issue(LS_OP_SW, 32'h10, 4'd0, 32'hDEAD_BEEF, 4'd0, 16'd4);
    issue(LS_OP_LW, 32'h10, 4'd0, 32'h0, 4'd0, 16'd4);
    tail_m = 2;
    wait_for(0, "b2b_we");
    check("b2b_we_addr", 32'(mem_addr), 32'd5);
    check("b2b_we_data", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("b2b_we_once", 32'(mem_we), 32'd0);
    requireAC = 1'b1;
    wait_for(2, "b2b_req");
    check("b2b_label", 32'(labelOut), 32'd13);
    check("b2b_data", dataOut, 32'hDEAD_BEEF);
    @(negedge clk);
    requireAC = 1'b0;
    check("b2b_req_drop", 32'(require), 32'd0);
    check("b2b_not_full", 32'(isFull), 32'd0);

    // Table of single operations
    foreach (vecs[k]) begin
      check($sformatf("v%0d_wlabel", k), 32'(writeable_labelOut), 32'd12 + 32'(tail_m));
      exp_lbl = 4'd12 + 4'(tail_m);
      issue(vecs[k].op, vecs[k].base, 4'd0, vecs[k].data, 4'd0, vecs[k].immd);
      tail_m = (tail_m + 1) % 4;
      if (vecs[k].op == LS_OP_SW) begin
        wait_for(0, $sformatf("v%0d_we", k));
        check($sformatf("v%0d_addr", k), 32'(mem_addr), 32'(vecs[k].exp_addr));
        check($sformatf("v%0d_wdata", k), mem_wdata, vecs[k].exp_val);
        @(negedge clk);
        check($sformatf("v%0d_we_once", k), 32'(mem_we), 32'd0);
      end else begin
        wait_for(1, $sformatf("v%0d_rd", k));
        check($sformatf("v%0d_addr", k), 32'(mem_addr), 32'(vecs[k].exp_addr));
        wait_for(2, $sformatf("v%0d_req", k));
        check($sformatf("v%0d_label", k), 32'(labelOut), 32'(exp_lbl));
        check($sformatf("v%0d_data", k), dataOut, vecs[k].exp_val);
        grant_pulse($sformatf("v%0d", k));
      end
    end

    // Pending base resolved by the CDB
    issue(LS_OP_LW, 32'hFFFF_FFFF, 4'd3, 32'h0, 4'd0, 16'd0);
    tail_m = (tail_m + 1) % 4;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd) seen++;
    end
    check("pend_no_rd", 32'(seen), 32'd0);
    bcast(4'd3, 32'h20);
    @(negedge clk);
    check("pend_rd", 32'(mem_rd), 32'd1);
    check("pend_addr", 32'(mem_addr), 32'd8);
    wait_for(2, "pend_req");
    check("pend_data", dataOut, 32'hC0DE_0008);
    grant_pulse("pend");

    // Issue-cycle bypass: tag broadcast in the same cycle as issue
    @(negedge clk);
    BCEN = 1'b1; BClabel = 4'd5; BCdata = 32'h24;
    issue(LS_OP_LW, 32'hFFFF_FFFF, 4'd5, 32'h0, 4'd0, 16'd0);
    BCEN = 1'b0;
    tail_m = (tail_m + 1) % 4;
    wait_for(1, "byp_rd");
    check("byp_addr", 32'(mem_addr), 32'd9);
    wait_for(2, "byp_req");
    grant_pulse("byp");

    // Fill the queue behind a pending base, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) issue(LS_OP_LW, 32'h0, 4'd7, 32'h0, 4'd0, 16'(4 * i));
    @(negedge clk);
    check("fill_full", 32'(isFull), 32'd1);
    issue(LS_OP_LW, 32'h0, 4'd0, 32'h0, 4'd0, 16'd0);
    @(negedge clk);
    check("fill_wlabel", 32'(writeable_labelOut), 32'd12);
    check("fill_still_full", 32'(isFull), 32'd1);
    bcast(4'd7, 32'h40);
    for (int k = 0; k < 4; k++) begin
      wait_for(2, $sformatf("drain%0d_req", k));
      check($sformatf("drain%0d_label", k), 32'(labelOut), 32'd12 + 32'(k));
      check($sformatf("drain%0d_data", k), dataOut, 32'hC0DE_0010 + 32'(k));
      grant_pulse($sformatf("drain%0d", k));
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (require || mem_rd) seen++;
    end
    check("drain_empty", 32'(seen), 32'd0);
    check("drain_not_full", 32'(isFull), 32'd0);

    // CDB backpressure
    issue(LS_OP_LW, 32'h80, 4'd0, 32'h0, 4'd0, 16'd0);
    wait_for(2, "bp_req");
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!require || dataOut !== 32'hC0DE_0020 || labelOut !== 4'd12) seen++;
    end
    check("bp_stable", 32'(seen), 32'd0);
    grant_pulse("bp");

    // Reset while a load waits in LD_CDB with three entries valid
    for (int i = 0; i < 3; i++) issue(LS_OP_LW, 32'h0, 4'd0, 32'h0, 4'd0, 16'd0);
    wait_for(2, "mid_req");
    do_reset();
    @(negedge clk);
    check("mid_require", 32'(require), 32'd0);
    check("mid_isFull", 32'(isFull), 32'd0);
    check("mid_wlabel", 32'(writeable_labelOut), 32'd12);
    check("mid_dataOut", dataOut, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (require || mem_rd || mem_we) seen++;
    end
    check("mid_empty", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
